lock_attempt_ctrl: RTL and testbench

LOCK_ATTEMPT_CTRL -- requirements
Module: lock_attempt_ctrl

---
 rtl/lock_pkg.sv | 25 ++
 rtl/sec_tick.sv | 28 ++
 rtl/lock_attempt_ctrl.sv | 144 ++++++++++++++
 tb/tb_lock_attempt_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared state encoding and status LED colours for the lock attempt controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_FAIL     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_t;

  // LED colours as {R,G,B}
  localparam logic [2:0] LED_BLUE  = 3'b001;
  localparam logic [2:0] LED_GREEN = 3'b010;
  localparam logic [2:0] LED_RED   = 3'b100;

  function automatic logic [2:0] led_for(input state_t s);
    case (s)
      ST_UNLOCKED:         return LED_GREEN;
      ST_FAIL, ST_LOCKOUT: return LED_RED;
      default:             return LED_BLUE;
    endcase
  endfunction

endpackage

// File: rtl/sec_tick.sv
// One-second tick prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick
// on the last count. clr restarts the period so the first tick lands TICK_DIV cycles later.
module sec_tick #(
  parameter int TICK_DIV = 125_000_000
) (
  input  logic clk_125Mhz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk_125Mhz) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lock_attempt_ctrl.sv
// Password attempt controller with retry limit, timed lockout and status outputs.
// Optional auto-relock of the UNLOCKED state is built when LOCK_AUTO_RELOCK_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | locked, waiting for enter
// CHECK    | one cycle: compare pass_in against pass_set
// UNLOCKED | open until cancel (or relock timeout when enabled)
// FAIL     | wrong entry, hold one tick period, enter ignored
// LOCKOUT  | retries exhausted, buttons disabled, count down lockout_sec
module lock_attempt_ctrl
  import lock_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int TICK_DIV    = 125_000_000,
  parameter int LOCKOUT_SEC = 30,
  parameter int RELOCK_SEC  = 10
) (
  input  logic        clk_125Mhz,
  input  logic        rst,
  input  logic        enter,
  input  logic        cancel,
  input  logic [11:0] pass_in,
  input  logic [11:0] pass_set,
  output logic        lock,
  output logic        btn_enb,
  output logic [3:0]  tries_left,
  output logic [7:0]  lockout_sec,
  output logic [2:0]  led_rgb
);

  if (MAX_TRIES < 1 || MAX_TRIES > 15)     $error("MAX_TRIES out of range 1..15");
  if (LOCKOUT_SEC < 1 || LOCKOUT_SEC > 255) $error("LOCKOUT_SEC out of range 1..255");
  if (RELOCK_SEC < 1 || RELOCK_SEC > 255)   $error("RELOCK_SEC out of range 1..255");
  if (TICK_DIV < 1)                         $error("TICK_DIV must be at least 1");

  state_t state, state_next;
  logic   tick;
  logic   tick_en;
  logic   tick_clr;
  logic   match;
  logic   relock_restart;

  assign match = (pass_in == pass_set);

`ifdef LOCK_AUTO_RELOCK_EN
  logic [7:0] relock_cnt;

  // Any enter while open restarts the relock window, including the prescaler phase.
  assign relock_restart = (state == ST_UNLOCKED) && enter && !cancel;
  assign tick_en        = (state == ST_FAIL) || (state == ST_LOCKOUT) || (state == ST_UNLOCKED);

  always_ff @(posedge clk_125Mhz) begin
    if (rst) begin
      relock_cnt <= 8'(RELOCK_SEC);
    end else if ((state_next == ST_UNLOCKED) && ((state != ST_UNLOCKED) || relock_restart)) begin
      relock_cnt <= 8'(RELOCK_SEC);
    end else if ((state == ST_UNLOCKED) && tick) begin
      relock_cnt <= relock_cnt - 8'd1;
    end
  end
`else
  assign relock_restart = 1'b0;
  assign tick_en        = (state == ST_FAIL) || (state == ST_LOCKOUT);
`endif

  assign tick_clr = (state_next != state) || relock_restart;

  sec_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_sec_tick (
    .clk_125Mhz(clk_125Mhz),
    .rst       (rst),
    .clr       (tick_clr),
    .en        (tick_en),
    .tick      (tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (enter && !cancel) state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (cancel)                   state_next = ST_IDLE;
        else if (match)               state_next = ST_UNLOCKED;
        else if (tries_left <= 4'd1)  state_next = ST_LOCKOUT;
        else                          state_next = ST_FAIL;
      end
      ST_UNLOCKED: begin
        if (cancel) state_next = ST_IDLE;
`ifdef LOCK_AUTO_RELOCK_EN
        else if (!enter && tick && (relock_cnt <= 8'd1)) state_next = ST_IDLE;
`endif
      end
      ST_FAIL: begin
        if (tick) state_next = ST_IDLE;
      end
      ST_LOCKOUT: begin
        if (tick && (lockout_sec <= 8'd1)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state exactly.
  always_ff @(posedge clk_125Mhz) begin
    if (rst) begin
      state       <= ST_IDLE;
      lock        <= 1'b1;
      btn_enb     <= 1'b1;
      led_rgb     <= LED_BLUE;
      tries_left  <= 4'(MAX_TRIES);
      lockout_sec <= 8'd0;
    end else begin
      state   <= state_next;
      lock    <= (state_next != ST_UNLOCKED);
      btn_enb <= (state_next != ST_LOCKOUT);
      led_rgb <= led_for(state_next);

      case (state)
        ST_CHECK: begin
          if (!cancel) begin
            if (match) begin
              tries_left <= 4'(MAX_TRIES);
            end else begin
              tries_left <= tries_left - 4'd1;
              if (tries_left <= 4'd1) lockout_sec <= 8'(LOCKOUT_SEC);
            end
          end
        end
        ST_LOCKOUT: begin
          if (tick) begin
            lockout_sec <= lockout_sec - 8'd1;
            if (lockout_sec <= 8'd1) tries_left <= 4'(MAX_TRIES);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_attempt_ctrl.sv
// Directed scoreboard bench for lock_attempt_ctrl with a 4-cycle tick.
// Honours LOCK_AUTO_RELOCK_EN to select the expected UNLOCKED behaviour.
module tb_lock_attempt_ctrl;
  import lock_pkg::*;

  localparam logic [2:0] LB = 3'b001;
  localparam logic [2:0] LG = 3'b010;
  localparam logic [2:0] LR = 3'b100;

  logic        clk_125Mhz = 1'b0;
  logic        rst = 1'b1;
  logic        enter = 1'b0;
  logic        cancel = 1'b0;
  logic [11:0] pass_in = 12'h122;
  logic [11:0] pass_set = 12'h122;
  logic        lock;
  logic        btn_enb;
  logic [3:0]  tries_left;
  logic [7:0]  lockout_sec;
  logic [2:0]  led_rgb;

  typedef struct packed {
    logic       l;
    logic       b;
    logic [3:0] t;
    logic [7:0] s;
    logic [2:0] led;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  lock_attempt_ctrl #(
    .MAX_TRIES  (3),
    .TICK_DIV   (4),
    .LOCKOUT_SEC(2),
    .RELOCK_SEC (2)
  ) dut (
    .clk_125Mhz (clk_125Mhz),
    .rst        (rst),
    .enter      (enter),
    .cancel     (cancel),
    .pass_in    (pass_in),
    .pass_set   (pass_set),
    .lock       (lock),
    .btn_enb    (btn_enb),
    .tries_left (tries_left),
    .lockout_sec(lockout_sec),
    .led_rgb    (led_rgb)
  );

  always #5 clk_125Mhz = ~clk_125Mhz;

  task automatic check_front();
    exp_t  x;
    string tg;
    x  = exp_q.pop_front();
    tg = tag_q.pop_front();
    n_tests++;
    assert (lock === x.l) else begin
      n_fail++; $error("FAIL %s lock: got %0b want %0b", tg, lock, x.l);
    end
    n_tests++;
    assert (btn_enb === x.b) else begin
      n_fail++; $error("FAIL %s btn_enb: got %0b want %0b", tg, btn_enb, x.b);
    end
    n_tests++;
    assert (tries_left === x.t) else begin
      n_fail++; $error("FAIL %s tries_left: got %0d want %0d", tg, tries_left, x.t);
    end
    n_tests++;
    assert (lockout_sec === x.s) else begin
      n_fail++; $error("FAIL %s lockout_sec: got %0d want %0d", tg, lockout_sec, x.s);
    end
    n_tests++;
    assert (led_rgb === x.led) else begin
      n_fail++; $error("FAIL %s led_rgb: got %b want %b", tg, led_rgb, x.led);
    end
  endtask

  // Drive one cycle of inputs, expect the given outputs right after the edge.
  task automatic st(input logic e, input logic c, input logic r, input string tag,
                    input logic l, input logic b, input logic [3:0] t,
                    input logic [7:0] s, input logic [2:0] led);
    exp_t x;
    x = '{l: l, b: b, t: t, s: s, led: led};
    exp_q.push_back(x);
    tag_q.push_back(tag);
    enter  = e;
    cancel = c;
    rst    = r;
    @(posedge clk_125Mhz);
    #1;
    enter  = 1'b0;
    cancel = 1'b0;
    rst    = 1'b0;
    check_front();
  endtask

  // Wrong entry that lands in FAIL for one tick period and returns to IDLE.
  task automatic fail_seq(input logic [3:0] t_before, input logic [3:0] t_after);
    st(1, 0, 0, "wrong_check", 1, 1, t_before, 0, LB);
    st(0, 0, 0, "wrong_fail",  1, 1, t_after,  0, LR);
    for (int i = 0; i < 3; i++) st(0, 0, 0, "wrong_hold", 1, 1, t_after, 0, LR);
    st(0, 0, 0, "wrong_exit", 1, 1, t_after, 0, LB);
  endtask

  initial begin
    st(0, 0, 1, "reset", 1, 1, 3, 0, LB);

    // correct password unlocks two cycles after enter
    st(1, 0, 0, "match_check",  1, 1, 3, 0, LB);
    st(0, 0, 0, "match_unlock", 0, 1, 3, 0, LG);
`ifdef LOCK_AUTO_RELOCK_EN
    for (int i = 0; i < 7; i++) st(0, 0, 0, "relock_hold", 0, 1, 3, 0, LG);
    st(0, 0, 0, "relock_fire", 1, 1, 3, 0, LB);
`else
    for (int i = 0; i < 100; i++) st(i == 50, 0, 0, "unlock_hold", 0, 1, 3, 0, LG);
    st(0, 1, 0, "unlock_cancel", 1, 1, 3, 0, LB);
`endif

    // wrong password: one tick in FAIL, enter ignored there
    pass_in = 12'h123;
    st(1, 0, 0, "bad_check",   1, 1, 3, 0, LB);
    st(0, 0, 0, "fail_enter",  1, 1, 2, 0, LR);
    st(0, 0, 0, "fail_hold",   1, 1, 2, 0, LR);
    st(1, 0, 0, "fail_enter_ignored", 1, 1, 2, 0, LR);
    st(0, 0, 0, "fail_hold",   1, 1, 2, 0, LR);
    st(0, 0, 0, "fail_exit",   1, 1, 2, 0, LB);

    // enter+cancel in IDLE is a no-op; cancel in CHECK aborts
    st(1, 1, 0, "both_idle",   1, 1, 2, 0, LB);
    st(0, 0, 0, "both_idle_1", 1, 1, 2, 0, LB);
    st(0, 0, 0, "both_idle_2", 1, 1, 2, 0, LB);
    st(1, 0, 0, "cancel_check_a", 1, 1, 2, 0, LB);
    st(0, 1, 0, "cancel_check_b", 1, 1, 2, 0, LB);
    st(0, 0, 0, "cancel_check_c", 1, 1, 2, 0, LB);

    // exhaust tries into LOCKOUT; enter/cancel have no effect
    fail_seq(2, 1);
    st(1, 0, 0, "lo_check", 1, 1, 1, 0, LB);
    st(0, 0, 0, "lo_enter", 1, 0, 0, 2, LR);
    st(0, 0, 0, "lo_s2",    1, 0, 0, 2, LR);
    st(1, 0, 0, "lo_s2_enter", 1, 0, 0, 2, LR);
    st(0, 1, 0, "lo_s2_cancel", 1, 0, 0, 2, LR);
    st(0, 0, 0, "lo_s1",    1, 0, 0, 1, LR);
    st(1, 1, 0, "lo_s1_both", 1, 0, 0, 1, LR);
    st(0, 1, 0, "lo_s1_cancel", 1, 0, 0, 1, LR);
    st(0, 0, 0, "lo_s1",    1, 0, 0, 1, LR);
    st(0, 0, 0, "lo_exit",  1, 1, 3, 0, LB);
    st(0, 0, 0, "lo_idle",  1, 1, 3, 0, LB);

    // reset in the middle of LOCKOUT
    fail_seq(3, 2);
    fail_seq(2, 1);
    st(1, 0, 0, "rl_check", 1, 1, 1, 0, LB);
    st(0, 0, 0, "rl_enter", 1, 0, 0, 2, LR);
    st(0, 0, 0, "rl_hold",  1, 0, 0, 2, LR);
    st(0, 0, 1, "rst_lockout", 1, 1, 3, 0, LB);
    st(0, 0, 0, "rst_lockout_idle", 1, 1, 3, 0, LB);

    // reset in the middle of CHECK
    fail_seq(3, 2);
    st(1, 0, 0, "rc_check", 1, 1, 2, 0, LB);
    st(0, 0, 1, "rst_check", 1, 1, 3, 0, LB);
    st(0, 0, 0, "rst_check_idle", 1, 1, 3, 0, LB);

    // normal unlock still works afterwards
    pass_in = 12'h122;
    st(1, 0, 0, "post_check",  1, 1, 3, 0, LB);
    st(0, 0, 0, "post_unlock", 0, 1, 3, 0, LG);
    st(0, 1, 0, "post_cancel", 1, 1, 3, 0, LB);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
